// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer and the SAR logic block.
package sar_pkg;

  localparam int DW      = 10;
  localparam int ACC_W   = DW + 4;
  localparam int OSR_MAX = 4;

  // Trim register reset values, common to the sequencer and the SAR core.
  localparam logic [4:0] TRIM_OFFSET_RST = 5'd16;
  localparam logic [2:0] TRIM_GAIN_RST   = 3'd4;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4,
    PUSH  = 3'd5
  } state_t;

  // Oversampling exponents above OSR_MAX saturate.
  function automatic logic [2:0] clamp_osr(input logic [2:0] osr);
    return (osr > 3'(OSR_MAX)) ? 3'(OSR_MAX) : osr;
  endfunction

endpackage

// File: rtl/sar_adc_seq_if.sv
// SAR-side request/response pins plus the averaged-result stream toward the bus/DSP.
interface sar_adc_seq_if #(
  parameter int DW = 10
);
  // SAR side: sar_en is a 1-cycle request (sar_cal qualifies it); sar_valid is a 1-cycle
  // completion with sar_result. Stream side: a word moves on every cycle where
  // out_valid && out_ready; out_data is stable while out_valid is high and not accepted.
  logic          sar_en;
  logic          sar_cal;
  logic          sar_valid;
  logic [DW-1:0] sar_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output sar_en, sar_cal, out_valid, out_data,
    input  sar_valid, sar_result, out_ready
  );

  modport slave (
    input  sar_en, sar_cal, out_valid, out_data,
    output sar_valid, sar_result, out_ready
  );
endinterface

// File: rtl/sar_res_fifo.sv
// Small synchronous FIFO for averaged results; a push on full succeeds only with a pop.
module sar_res_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | do_rd);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/sar_adc_seq.sv
// Conversion sequencer in front of the SAR core: boot calibration, oversampled
// averaging, window alarm and a result FIFO toward the consumer.
module sar_adc_seq #(
  parameter int DW         = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 127,
  parameter int AUTO_CAL   = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            cont,
  input  logic            cal_req,
  input  logic [7:0]      gap,
  input  logic [2:0]      osr_log2,
  input  logic [DW-1:0]   thr_lo,
  input  logic [DW-1:0]   thr_hi,
  input  logic            alarm_clr,
  sar_adc_seq_if.master   bus,
  output logic            busy,
  output logic            cal_done,
  output logic            alarm,
  output logic            ovf,
  output logic            err,
  output sar_pkg::state_t dbg_state
);

  import sar_pkg::*;

  // Four headroom bits cover 16 full-scale results.
  localparam int AW = DW + (ACC_W - sar_pkg::DW);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_d;
  logic          boot_cnt;
  logic          cal_q;
  logic          pend_cal;
  logic [AW-1:0] acc;
  logic [4:0]    cnt;
  logic [2:0]    osr_n;
  logic [4:0]    osr_len;
  logic [7:0]    gap_q;
  logic [7:0]    gap_cnt;
  logic [TW-1:0] to_cnt;

  logic          win_start;
  logic          cal_load;
  logic          cal_val;
  logic          acc_add;
  logic          gap_load;
  logic          timeout;
  logic          cal_fin;
  logic          push_now;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          out_of_win;
  logic [DW-1:0] avg;

  assign osr_len    = 5'd1 << osr_n;
  assign push_now   = (state == PUSH);
  assign avg        = DW'(acc >> osr_n);
  assign out_of_win = (avg < thr_lo) || (avg > thr_hi);
  assign pop        = ~fifo_empty & bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    win_start = 1'b0;
    cal_load  = 1'b0;
    cal_val   = 1'b0;
    acc_add   = 1'b0;
    gap_load  = 1'b0;
    timeout   = 1'b0;
    cal_fin   = 1'b0;
    case (state)
      BOOT: if (boot_cnt) state_d = IDLE;
      IDLE: begin
        if (pend_cal) begin
          state_d  = ISSUE;
          cal_load = 1'b1;
          cal_val  = 1'b1;
        end else if (start || cont) begin
          state_d   = ISSUE;
          win_start = 1'b1;
          cal_load  = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.sar_valid) begin
          if (cal_q) begin
            cal_fin = 1'b1;
            state_d = IDLE;
          end else begin
            acc_add = 1'b1;
            if (cnt + 5'd1 == osr_len) begin
              state_d = PUSH;
            end else if (gap_q == 8'd0) begin
              state_d = ISSUE;
            end else begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end
        end else if (to_cnt == TW'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: if (gap_cnt <= 8'd1) state_d = ISSUE;
      PUSH: begin
        // A pending calibration runs between windows, never inside one.
        if (pend_cal) begin
          state_d  = ISSUE;
          cal_load = 1'b1;
          cal_val  = 1'b1;
        end else if (cont) begin
          win_start = 1'b1;
          cal_load  = 1'b1;
          if (gap == 8'd0) begin
            state_d = ISSUE;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      boot_cnt <= 1'b0;
      cal_q    <= 1'b0;
      pend_cal <= (AUTO_CAL != 0);
      acc      <= '0;
      cnt      <= '0;
      osr_n    <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      cal_done <= 1'b0;
      alarm    <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == BOOT) boot_cnt <= 1'b1;
      if (cal_load) cal_q <= cal_val;

      // Window parameters are latched once per window so mid-window changes are inert.
      if (win_start) begin
        acc   <= '0;
        cnt   <= '0;
        osr_n <= clamp_osr(osr_log2);
        gap_q <= gap;
      end else if (acc_add) begin
        acc <= acc + AW'(bus.sar_result);
        cnt <= cnt + 5'd1;
      end else if (timeout || push_now) begin
        acc <= '0;
        cnt <= '0;
      end

      if (gap_load)           gap_cnt <= win_start ? gap : gap_q;
      else if (state == GAP)  gap_cnt <= gap_cnt - 8'd1;

      if (state == ISSUE)     to_cnt <= TW'(1);
      else if (state == WAIT) to_cnt <= to_cnt + TW'(1);

      pend_cal <= (pend_cal & ~cal_fin) | cal_req;
      cal_done <= cal_done | cal_fin;
      err      <= (err   & ~alarm_clr) | timeout;
      alarm    <= (alarm & ~alarm_clr) | (push_now & out_of_win);
      ovf      <= (ovf   & ~alarm_clr) | (push_now & fifo_full & ~pop);
    end
  end

  sar_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_now),
    .pop   (pop),
    .din   (avg),
    .dout  (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.sar_en    = (state == ISSUE);
  assign bus.sar_cal   = (state == ISSUE) & cal_q;
  assign busy          = (state != IDLE) && (state != BOOT);
  assign dbg_state     = state;

endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
- Conversion sequencer placed directly in front of the 10-bit SAR logic block. Drives its `en`/`cal` inputs and consumes its `valid`/`result` outputs.
- Schedules single-shot or continuous conversions, runs offset calibration automatically at boot and on request, and averages 2^osr_log2 raw results per output sample.
- Applies a window alarm and buffers averaged results in a small ready/valid FIFO toward the bus/DSP side.

Parameters:
- DW, 10, SAR result width.
- FIFO_DEPTH, 4, averaged-result FIFO entries (power of 2).
- TIMEOUT, 127, max cycles from sar_en to sar_valid before error.
- AUTO_CAL, 1, run one calibration after reset before accepting conversions.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  one-cycle pulse; begin one averaged sample (ignored if busy)
- cont  in  1  continuous mode while high
- cal_req  in  1  one-cycle pulse; request calibration (queued if busy)
- gap  in  8  idle cycles between raw conversions
- osr_log2  in  3  average 2^n raw results, n=0..4 (5..7 clamp to 4)
- thr_lo  in  DW  window low threshold
- thr_hi  in  DW  window high threshold
- alarm_clr  in  1  clear sticky flags
- sar_en  out  1  conversion request to SAR
- sar_cal  out  1  calibrate qualifier to SAR, valid with sar_en
- sar_valid  in  1  SAR done pulse (1 cycle)
- sar_result  in  DW  SAR result, valid with sar_valid
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accept
- out_data  out  DW  averaged result, FIFO head
- busy  out  1  state != IDLE
- cal_done  out  1  sticky; at least one calibration completed
- alarm  out  1  sticky; an averaged result < thr_lo or > thr_hi
- ovf  out  1  sticky; averaged result dropped on full FIFO
- err  out  1  sticky; SAR timeout

Behaviour:
- Reset (rstn low, async): all outputs 0, FIFO empty, accumulator 0, state BOOT, pending-cal flag = AUTO_CAL.
- Reset mid-conversion aborts everything. No partial result is pushed.
- States:
  - BOOT: wait 2 cycles so the SAR leaves its init state, then go to IDLE.
  - IDLE:
    - If pending-cal is set, go to ISSUE with cal=1.
    - Else if start or cont, clear acc and count, go to ISSUE with cal=0.
    - Pending-cal has priority over start. A start in the same cycle is dropped.
  - ISSUE: sar_en=1 and sar_cal=cal for exactly one cycle, then go to WAIT.
  - WAIT: timeout counter runs.
    - sar_valid with cal=1: set cal_done, clear pending-cal, go to IDLE.
    - sar_valid with cal=0: acc += sar_result (DW+4 bits, no overflow possible), count++.
      - If count == 2^n: go to PUSH.
      - Else go to GAP, or to ISSUE if gap==0.
    - Counter reaches TIMEOUT without sar_valid: set err, discard acc, go to IDLE.
  - GAP: count down gap cycles, then go to ISSUE.
  - PUSH (1 cycle):
    - avg = acc >> n (truncating).
    - Push to FIFO if not full, else set ovf and drop.
    - alarm set if avg<thr_lo or avg>thr_hi (unsigned).
    - Then: pending-cal → ISSUE(cal=1); else cont → clear acc, GAP/ISSUE; else IDLE.
- cal_req while busy sets pending-cal. It is serviced at the next PUSH or IDLE boundary and never interrupts an averaging window. If cal_req and sar_valid arrive in the same cycle, both take effect.
- osr_log2 and gap are sampled at window start (IDLE→ISSUE, or PUSH→next window). Changes mid-window have no effect.
- sar_valid outside WAIT is ignored.
- FIFO:
  - out_data is the head entry; out_valid = !empty.
  - A pop happens when out_valid && out_ready.
  - Push and pop in the same cycle on a full FIFO: pop frees space, push succeeds, no ovf.
  - Pointers wrap modulo FIFO_DEPTH.
- alarm_clr clears alarm, ovf and err next cycle. If a flag's set condition occurs in the same cycle as the clear, set wins.
- Latency: sar_valid to out_valid is 2 cycles (PUSH, then registered FIFO write), given an empty FIFO.

Decomposition:
- Package sar_pkg:
  - state enum (BOOT, IDLE, ISSUE, WAIT, GAP, PUSH).
  - DW, ACC_W=DW+4, OSR_MAX=4.
  - Reset values for trim are shared with the SAR logic block.
- One sub-module: sar_res_fifo, a synchronous FIFO with parameters DEPTH and DW and ports push, pop, din, dout, full, empty.

Test Plan:
- Boot with AUTO_CAL=1; SAR model answers cal in 60 cycles → exactly one sar_en pulse with sar_cal=1; cal_done=1; busy drops; no FIFO push.
- osr_log2=2, gap=0, start, model returns 100,101,102,104 → one push of out_data=101; exactly 4 sar_en pulses, each 1 cycle wide.
- cont=1, osr_log2=0, out_ready=0, 6 results → FIFO holds the first 4, ovf=1. Set out_ready=1 → 4 values drain in order. alarm_clr → ovf=0.
- thr_lo=200, thr_hi=800, osr=0, results 150, 500, 900 → alarm first set on the 150 result, still 1 after 500; after alarm_clr, set again on 900.
- cal_req during the 2nd raw conversion of an osr=2 window → the window completes and pushes, then the cal conversion issues before the next window.
- Model never returns sar_valid → err=1 at TIMEOUT+1 cycles after sar_en, state back in IDLE. Assert rstn low mid-WAIT → all outputs 0 immediately.
